multi_timer_control: RTL and testbench

//  Parametrised N-channel controller for the kitchen timer. Each channel holds its own run-state
//  FSM (PROG/LOAD/RUN/PAUSE/DONE) and adds pause/resume and clear. A bounded alarm window per

---
 rtl/multi_timer_pkg.sv | 19 +
 rtl/timer_channel_fsm.sv | 113 +++++++++++
 rtl/multi_timer_control.sv | 121 ++++++++++++
 tb/tb_multi_timer_control.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel kitchen timer controller.
//   - Per-channel run-state encodings (3-bit).
//   - ch_width(): width of a channel index, never less than one bit.
package multi_timer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t PROG  = 3'd1;
    localparam state_t LOAD  = 3'd2;
    localparam state_t RUN   = 3'd3;
    localparam state_t PAUSE = 3'd4;
    localparam state_t DONE  = 3'd5;

    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/timer_channel_fsm.sv
// One timer channel: run-state FSM, alarm window counter and state decode.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   sel               this channel is the one addressed by the shared buttons
//   cooktime_req      level: program request
//   start_req         pulse: load and start
//   pause_req         pulse: toggle RUN/PAUSE
//   clear_req         pulse: back to IDLE
//   timer_done        this channel's countdown reached zero
//   prog_mode         state is PROG
//   load_timer        state is LOAD
//   run               state is RUN
//   paused            state is PAUSE
//   alarm_active      in DONE and the alarm window has not yet expired
module timer_channel_fsm
    import multi_timer_pkg::*;
#(
    parameter int unsigned ALARM_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sel,
    input  logic cooktime_req,
    input  logic start_req,
    input  logic pause_req,
    input  logic clear_req,
    input  logic timer_done,
    output logic prog_mode,
    output logic load_timer,
    output logic run,
    output logic paused,
    output logic alarm_active
);

    localparam int unsigned CNT_W = $clog2(ALARM_CYCLES + 1);
    localparam logic [CNT_W-1:0] ALARM_LOAD = CNT_W'(ALARM_CYCLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] alarm_cnt_q, alarm_cnt_d;

    // Commands only count when this channel is the selected one.
    logic clear, cook, start, pause;
    assign clear = sel & clear_req;
    assign cook  = sel & cooktime_req;
    assign start = sel & start_req;
    assign pause = sel & pause_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            alarm_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (clear)      state_d = IDLE;
                else if (cook)  state_d = PROG;
                else if (start) state_d = LOAD;
            end
            PROG: begin
                if (clear)      state_d = IDLE;
                else if (cook)  state_d = PROG;
                else if (start) state_d = LOAD;
            end
            LOAD: state_d = RUN;
            RUN: begin
                // timer_done acts even when unselected; only clear outranks it.
                if (clear)           state_d = IDLE;
                else if (timer_done) state_d = DONE;
                else if (cook)       state_d = PROG;
                else if (pause)      state_d = PAUSE;
            end
            PAUSE: begin
                if (clear)               state_d = IDLE;
                else if (cook)           state_d = PROG;
                else if (start || pause) state_d = RUN;
            end
            DONE: begin
                if (clear)      state_d = IDLE;
                else if (cook)  state_d = PROG;
                else if (start) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    // Alarm window: load on DONE entry, count down while in DONE, drop on exit.
    always_comb begin
        alarm_cnt_d = alarm_cnt_q;
        if (state_d != DONE) begin
            alarm_cnt_d = '0;
        end else if (state_q != DONE) begin
            alarm_cnt_d = ALARM_LOAD;
        end else if (alarm_cnt_q != '0) begin
            alarm_cnt_d = alarm_cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        prog_mode    = (state_q == PROG);
        load_timer   = (state_q == LOAD);
        run          = (state_q == RUN);
        paused       = (state_q == PAUSE);
        alarm_active = (state_q == DONE) && (alarm_cnt_q != '0);
    end

endmodule

// File: rtl/multi_timer_control.sv
// N-channel kitchen timer controller. One shared set of buttons is steered to the
// channel chosen by ch_sel; each channel runs its own PROG/LOAD/RUN/PAUSE/DONE FSM.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   ch_sel                              selected channel (out-of-range: commands ignored)
//   cooktime_req/start_req/pause_req/clear_req  shared command inputs
//   seconds_req/minutes_req             user increment requests
//   timer_done[NUM_CH]                  per-channel countdown reached zero
//   increment_seconds/minutes           requests passed through while selected channel is in PROG
//   prog_mode/load_timer/main_timer_enable/timer_enabled_led/timer_on_led  per-channel decode
//   alarm, alarm_ch                     any alarm active, lowest-index active channel
module multi_timer_control
    import multi_timer_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned BLINK_DIV    = 2,
    parameter int unsigned ALARM_CYCLES = 16,
    localparam int unsigned CH_W        = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic              cooktime_req,
    input  logic              start_req,
    input  logic              pause_req,
    input  logic              clear_req,
    input  logic              seconds_req,
    input  logic              minutes_req,
    input  logic [NUM_CH-1:0] timer_done,
    output logic              increment_seconds,
    output logic              increment_minutes,
    output logic [NUM_CH-1:0] prog_mode,
    output logic [NUM_CH-1:0] load_timer,
    output logic [NUM_CH-1:0] main_timer_enable,
    output logic [NUM_CH-1:0] timer_enabled_led,
    output logic [NUM_CH-1:0] timer_on_led,
    output logic              alarm,
    output logic [CH_W-1:0]   alarm_ch
);

    localparam int unsigned DIV_W = (BLINK_DIV <= 1) ? 1 : $clog2(BLINK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BLINK_DIV - 1);
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

    logic              sel_valid;
    logic [NUM_CH-1:0] ch_hit;
    logic [NUM_CH-1:0] run_vec;
    logic [NUM_CH-1:0] pause_vec;
    logic [NUM_CH-1:0] alarm_vec;

    logic [DIV_W-1:0]  div_q, div_d;
    logic              flash_q, flash_d;

    // Extra top bit so a full-width ch_sel can be compared against NUM_CH.
    assign sel_valid = ({1'b0, ch_sel} < NUM_CH_L);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign ch_hit[c] = sel_valid && (ch_sel == CH_W'(c));

        timer_channel_fsm #(
            .ALARM_CYCLES (ALARM_CYCLES)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .sel          (ch_hit[c]),
            .cooktime_req (cooktime_req),
            .start_req    (start_req),
            .pause_req    (pause_req),
            .clear_req    (clear_req),
            .timer_done   (timer_done[c]),
            .prog_mode    (prog_mode[c]),
            .load_timer   (load_timer[c]),
            .run          (run_vec[c]),
            .paused       (pause_vec[c]),
            .alarm_active (alarm_vec[c])
        );
    end

    // Shared flash divider: free-runs only while some channel is in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            flash_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            flash_q <= flash_d;
        end
    end

    always_comb begin
        div_d   = '0;
        flash_d = 1'b0;
        if (|run_vec) begin
            if (div_q == DIV_MAX) begin
                div_d   = '0;
                flash_d = ~flash_q;
            end else begin
                div_d   = div_q + DIV_W'(1);
                flash_d = flash_q;
            end
        end
    end

    always_comb begin
        main_timer_enable = run_vec;
        timer_enabled_led = run_vec | pause_vec;
        timer_on_led      = run_vec & {NUM_CH{flash_q}};
        increment_seconds = seconds_req & |(prog_mode & ch_hit);
        increment_minutes = minutes_req & |(prog_mode & ch_hit);
        alarm             = |alarm_vec;
    end

    // Scan high to low so the lowest active index wins.
    always_comb begin
        alarm_ch = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (alarm_vec[i]) alarm_ch = CH_W'(i);
        end
    end

endmodule

// File: tb/tb_multi_timer_control.sv
module tb_multi_timer_control;

    localparam int NC = 2;
    localparam int BD = 2;
    localparam int AC = 4;

    localparam int M_IDLE  = 0;
    localparam int M_PROG  = 1;
    localparam int M_LOAD  = 2;
    localparam int M_RUN   = 3;
    localparam int M_PAUSE = 4;
    localparam int M_DONE  = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [0:0] ch_sel = 1'b0;
    logic       cooktime_req = 1'b0, start_req = 1'b0, pause_req = 1'b0, clear_req = 1'b0;
    logic       seconds_req = 1'b0, minutes_req = 1'b0;
    logic [1:0] timer_done = 2'b00;

    logic       increment_seconds, increment_minutes, alarm;
    logic [1:0] prog_mode, load_timer, main_timer_enable, timer_enabled_led, timer_on_led;
    logic [0:0] alarm_ch;

    // Second instance with 3 channels: ch_sel=3 is out of range there.
    logic [1:0] ch_sel3 = 2'd3;
    logic [2:0] timer_done3 = 3'b000;
    logic       inc_s3, inc_m3, alarm3;
    logic [2:0] prog3, load3, en3, led3, on3;
    logic [1:0] alarm_ch3;

    always #5 clk = ~clk;

    multi_timer_control #(
        .NUM_CH (NC), .BLINK_DIV (BD), .ALARM_CYCLES (AC)
    ) u_dut (
        .clk               (clk),
        .reset             (reset),
        .ch_sel            (ch_sel),
        .cooktime_req      (cooktime_req),
        .start_req         (start_req),
        .pause_req         (pause_req),
        .clear_req         (clear_req),
        .seconds_req       (seconds_req),
        .minutes_req       (minutes_req),
        .timer_done        (timer_done),
        .increment_seconds (increment_seconds),
        .increment_minutes (increment_minutes),
        .prog_mode         (prog_mode),
        .load_timer        (load_timer),
        .main_timer_enable (main_timer_enable),
        .timer_enabled_led (timer_enabled_led),
        .timer_on_led      (timer_on_led),
        .alarm             (alarm),
        .alarm_ch          (alarm_ch)
    );

    multi_timer_control #(
        .NUM_CH (3), .BLINK_DIV (BD), .ALARM_CYCLES (AC)
    ) u_dut3 (
        .clk               (clk),
        .reset             (reset),
        .ch_sel            (ch_sel3),
        .cooktime_req      (cooktime_req),
        .start_req         (start_req),
        .pause_req         (pause_req),
        .clear_req         (clear_req),
        .seconds_req       (seconds_req),
        .minutes_req       (minutes_req),
        .timer_done        (timer_done3),
        .increment_seconds (inc_s3),
        .increment_minutes (inc_m3),
        .prog_mode         (prog3),
        .load_timer        (load3),
        .main_timer_enable (en3),
        .timer_enabled_led (led3),
        .timer_on_led      (on3),
        .alarm             (alarm3),
        .alarm_ch          (alarm_ch3)
    );

    int n_pass = 0;
    int n_checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: channel state, edges spent in DONE, edges of continuous RUN activity.
    int m_st  [NC];
    int m_age [NC];
    int m_k;

    initial begin
        for (int c = 0; c < NC; c++) begin
            m_st[c]  = M_IDLE;
            m_age[c] = 0;
        end
        m_k = 0;
    end

    function automatic int nxt(input int s, input bit sel, input bit cook, input bit st,
                               input bit pa, input bit cl, input bit td);
        case (s)
            M_IDLE, M_PROG: return (sel && cl) ? M_IDLE : (sel && cook) ? M_PROG :
                                   (sel && st) ? M_LOAD : s;
            M_LOAD:  return M_RUN;
            M_RUN:   return (sel && cl) ? M_IDLE : td ? M_DONE : (sel && cook) ? M_PROG :
                            (sel && pa) ? M_PAUSE : M_RUN;
            M_PAUSE: return (sel && cl) ? M_IDLE : (sel && cook) ? M_PROG :
                            (sel && (st || pa)) ? M_RUN : M_PAUSE;
            M_DONE:  return (sel && cl) ? M_IDLE : (sel && cook) ? M_PROG :
                            (sel && st) ? M_LOAD : M_DONE;
            default: return M_IDLE;
        endcase
    endfunction

    always @(posedge clk) begin
        int  ns;
        bit  any_run;
        if (reset) begin
            for (int c = 0; c < NC; c++) begin
                m_st[c]  = M_IDLE;
                m_age[c] = 0;
            end
            m_k = 0;
        end else begin
            any_run = 1'b0;
            for (int c = 0; c < NC; c++) if (m_st[c] == M_RUN) any_run = 1'b1;
            for (int c = 0; c < NC; c++) begin
                ns = nxt(m_st[c], int'(ch_sel) == c, cooktime_req, start_req, pause_req,
                         clear_req, timer_done[c]);
                if (ns == M_DONE) m_age[c] = (m_st[c] == M_DONE) ? m_age[c] + 1 : 0;
                m_st[c] = ns;
            end
            m_k = any_run ? m_k + 1 : 0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [1:0] e_prog, e_load, e_en, e_led, e_on, e_al;
        logic [0:0] e_alch;
        for (int c = 0; c < NC; c++) begin
            e_prog[c] = (m_st[c] == M_PROG);
            e_load[c] = (m_st[c] == M_LOAD);
            e_en[c]   = (m_st[c] == M_RUN);
            e_led[c]  = (m_st[c] == M_RUN) || (m_st[c] == M_PAUSE);
            e_on[c]   = (m_st[c] == M_RUN) && (((m_k / BD) % 2) == 1);
            e_al[c]   = (m_st[c] == M_DONE) && (m_age[c] < AC);
        end
        e_alch = (!e_al[0] && e_al[1]) ? 1'b1 : 1'b0;
        chk("prog_mode", 32'(prog_mode), 32'(e_prog));
        chk("load_timer", 32'(load_timer), 32'(e_load));
        chk("main_timer_enable", 32'(main_timer_enable), 32'(e_en));
        chk("timer_enabled_led", 32'(timer_enabled_led), 32'(e_led));
        chk("timer_on_led", 32'(timer_on_led), 32'(e_on));
        chk("alarm", 32'(alarm), 32'(|e_al));
        chk("alarm_ch", 32'(alarm_ch), 32'(e_alch));
        chk("increment_seconds", 32'(increment_seconds),
            32'(seconds_req && m_st[ch_sel] == M_PROG));
        chk("increment_minutes", 32'(increment_minutes),
            32'(minutes_req && m_st[ch_sel] == M_PROG));
        chk("out_of_range_sel", 32'({inc_s3, inc_m3, prog3, load3, en3, led3, on3, alarm3,
                                     alarm_ch3}), 32'd0);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Command table: {sel, cook, start, pause, clear, td[1:0]}.
    logic [6:0] vec [20] = '{
        7'b1_1_0_0_0_00, 7'b1_0_0_0_0_00, 7'b1_0_0_0_1_00, 7'b1_1_1_0_0_00,
        7'b1_0_1_0_0_00, 7'b1_0_0_0_0_00, 7'b1_0_0_1_0_00, 7'b1_1_0_0_0_00,
        7'b1_0_1_0_0_00, 7'b1_0_0_0_0_00, 7'b1_1_0_0_0_10, 7'b1_0_1_0_0_00,
        7'b1_0_0_0_1_00, 7'b1_1_0_0_0_00, 7'b0_0_1_0_0_00, 7'b0_0_0_1_0_00,
        7'b0_0_0_1_0_00, 7'b0_0_1_0_0_00, 7'b0_0_0_0_1_01, 7'b0_0_0_0_0_00
    };

    initial begin
        cyc(); cyc();
        chk("reset_prog", 32'(prog_mode), 32'd0);
        chk("reset_alarm", 32'(alarm), 32'd0);

        // Program channel 1; channel 0 stays idle.
        reset = 1'b0; ch_sel = 1'b1; cooktime_req = 1'b1; seconds_req = 1'b1;
        cyc();
        chk("t1_prog", 32'(prog_mode), 32'd2);
        chk("t1_inc_sec", 32'(increment_seconds), 32'd1);
        cooktime_req = 1'b0; seconds_req = 1'b0; minutes_req = 1'b1;
        cyc();
        chk("t1_prog_hold", 32'(prog_mode), 32'd2);
        chk("t1_inc_min", 32'(increment_minutes), 32'd1);
        minutes_req = 1'b0;

        // Start: one LOAD cycle then RUN with flashing LED.
        start_req = 1'b1;
        cyc();
        start_req = 1'b0;
        chk("t2_load", 32'(load_timer), 32'd2);
        cyc();
        chk("t2_load_gone", 32'(load_timer), 32'd0);
        chk("t2_enable", 32'(main_timer_enable), 32'd2);
        chk("t2_led_a", 32'(timer_on_led), 32'd0);
        cyc(); chk("t2_led_b", 32'(timer_on_led), 32'd0);
        cyc(); chk("t2_led_c", 32'(timer_on_led), 32'd2);
        cyc(); chk("t2_led_d", 32'(timer_on_led), 32'd2);
        cyc(); chk("t2_led_e", 32'(timer_on_led), 32'd0);

        // Pause, done ignored while paused, resume without reload.
        pause_req = 1'b1;
        cyc();
        pause_req = 1'b0;
        chk("t3_pause_en", 32'(main_timer_enable), 32'd0);
        chk("t3_pause_led", 32'(timer_enabled_led), 32'd2);
        chk("t3_pause_on", 32'(timer_on_led), 32'd0);
        timer_done = 2'b10;
        cyc();
        timer_done = 2'b00;
        chk("t3_done_ignored", 32'(timer_enabled_led), 32'd2);
        pause_req = 1'b1;
        cyc();
        pause_req = 1'b0;
        chk("t3_resume_en", 32'(main_timer_enable), 32'd2);
        chk("t3_resume_noload", 32'(load_timer), 32'd0);

        // Both running, simultaneous done: alarm for exactly AC cycles.
        ch_sel = 1'b0; start_req = 1'b1;
        cyc();
        start_req = 1'b0;
        chk("t4_load0", 32'(load_timer), 32'd1);
        cyc();
        chk("t4_both_run", 32'(main_timer_enable), 32'd3);
        timer_done = 2'b11;
        cyc();
        timer_done = 2'b00;
        chk("t4_alarm_1", 32'(alarm), 32'd1);
        chk("t4_alarm_ch", 32'(alarm_ch), 32'd0);
        for (int i = 2; i <= AC; i++) begin
            cyc();
            chk("t4_alarm_window", 32'(alarm), 32'd1);
        end
        cyc();
        chk("t4_alarm_off", 32'(alarm), 32'd0);

        // Done beats pause; clear beats start.
        start_req = 1'b1;
        cyc();
        start_req = 1'b0;
        cyc();
        chk("t5_run0", 32'(main_timer_enable), 32'd1);
        pause_req = 1'b1; timer_done = 2'b01;
        cyc();
        pause_req = 1'b0; timer_done = 2'b00;
        chk("t5_done_not_pause", 32'(timer_enabled_led), 32'd0);
        chk("t5_done_alarm", 32'(alarm), 32'd1);
        clear_req = 1'b1; start_req = 1'b1;
        cyc();
        clear_req = 1'b0; start_req = 1'b0;
        chk("t5_clear_load", 32'(load_timer), 32'd0);
        chk("t5_clear_alarm", 32'(alarm), 32'd0);

        // Zero time loaded: done in first RUN cycle.
        start_req = 1'b1;
        cyc();
        start_req = 1'b0;
        cyc();
        chk("zt_run", 32'(main_timer_enable), 32'd1);
        timer_done = 2'b01;
        cyc();
        timer_done = 2'b00;
        chk("zt_alarm", 32'(alarm), 32'd1);

        // Channel 1 alarm takes over alarm_ch once channel 0's window ends.
        ch_sel = 1'b1; start_req = 1'b1;
        cyc();
        start_req = 1'b0;
        cyc();
        timer_done = 2'b10;
        cyc();
        timer_done = 2'b00;
        chk("ach_still0", 32'(alarm_ch), 32'd0);
        cyc();
        chk("ach_now1", 32'(alarm_ch), 32'd1);
        chk("ach_alarm", 32'(alarm), 32'd1);

        // Directed command table, model-checked each cycle.
        for (int i = 0; i < 20; i++) begin
            ch_sel = vec[i][6];
            cooktime_req = vec[i][5];
            start_req = vec[i][4];
            pause_req = vec[i][3];
            clear_req = vec[i][2];
            timer_done = vec[i][1:0];
            cyc();
        end
        {cooktime_req, start_req, pause_req, clear_req} = 4'b0000;
        timer_done = 2'b00;
        chk("tbl_prog1", 32'(prog_mode), 32'd2);

        // Reset while running.
        ch_sel = 1'b1; start_req = 1'b1;
        cyc();
        start_req = 1'b0;
        cyc();
        chk("t6_run", 32'(main_timer_enable), 32'd2);
        reset = 1'b1;
        cyc();
        chk("t6_reset_outs", 32'({prog_mode, load_timer, main_timer_enable, timer_enabled_led,
                                  timer_on_led, alarm, alarm_ch}), 32'd0);
        reset = 1'b0;
        cyc(); cyc();
        chk("t6_no_load_after", 32'(load_timer), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
